// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states,
// datapath select codes and trap causes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_JR     = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14,
        S_UNUSED = 4'd15
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [2:0] BT_BEQ  = 3'b000;
    localparam logic [2:0] BT_BNE  = 3'b001;
    localparam logic [2:0] BT_BGEZ = 3'b010;
    localparam logic [2:0] BT_BGTZ = 3'b011;
    localparam logic [2:0] BT_BLEZ = 3'b100;
    localparam logic [2:0] BT_BLTZ = 3'b101;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // REGIMM uses rt[0] to pick bgez (1) over bltz (0).
    function automatic logic [2:0] branch_type_of(input logic [5:0] op, input logic rt0);
        logic [2:0] bt;
        case (op)
            OP_BEQ:    bt = BT_BEQ;
            OP_BNE:    bt = BT_BNE;
            OP_BGTZ:   bt = BT_BGTZ;
            OP_BLEZ:   bt = BT_BLEZ;
            OP_REGIMM: bt = rt0 ? BT_BGEZ : BT_BLTZ;
            default:   bt = BT_BEQ;
        endcase
        return bt;
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags a timeout
// on the cycle the count reaches MAX_WAIT-1 with memory still not ready.
module mem_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ready_i,
    input  logic leave_i,
    output logic timeout_o
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Next count: restart on any state change, completed access or non-memory state
    always_comb begin
        count_d = count_q;
        if (!active_i || ready_i || leave_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = active_i && !ready_i && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing a shared ALU and
// memory port, with memory-ready handshake, wait watchdog and sticky traps.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW      = 6,
    parameter int FNW      = 6,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 12,
    parameter int RA_REG   = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic [4:0]     rt,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           pcwritecond,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           irwrite,
    output logic [1:0]     regdest,
    output logic [1:0]     memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [2:0]     aluop,
    output logic [1:0]     pcsource,
    output logic [2:0]     branch_type,
    output logic [4:0]     link_reg,
    output logic           trap,
    output logic [1:0]     trap_cause,
    output logic [3:0]     state_o
);

    state_e     state_q;
    state_e     state_d;
    logic       trap_q;
    logic       trap_d;
    logic [1:0] cause_q;
    logic [1:0] cause_d;
    logic [1:0] fault_s;
    logic       wait_active_s;
    logic       leave_s;
    logic       timeout_s;

    assign wait_active_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign leave_s       = (state_d != state_q);
    assign link_reg      = 5'(RA_REG);

    mem_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active_i  (wait_active_s),
        .ready_i   (mem_ready),
        .leave_i   (leave_s),
        .timeout_o (timeout_s)
    );

    // State and sticky trap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Next-state decode; any fault funnels into TRAP and latches its cause
    always_comb begin
        state_d = state_q;
        fault_s = CAUSE_NONE;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    fault_s = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BRANCH;
                    OP_REGIMM: begin
                        if (rt[4:1] == 4'b0000) begin
                            state_d = S_BRANCH;
                        end else begin
                            fault_s = CAUSE_ILLEGAL;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI:         state_d = S_IMMEX;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default:                          fault_s = CAUSE_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    fault_s = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    fault_s = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        if (fault_s != CAUSE_NONE) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = fault_s;
        end else begin
            trap_d  = trap_q;
            cause_d = cause_q;
        end
    end

    // Moore output decode; everything is forced low while reset is asserted
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdest     = 2'b00;
        memtoreg    = 2'b00;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = ALU_ADD;
        pcsource    = PCS_ALU;
        branch_type = BT_BEQ;
        trap        = trap_q;
        trap_cause  = cause_q;
        state_o     = state_q;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 2'b01;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALU_FUNCT;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdest  = 2'b01;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = ALU_SUB;
                    pcwritecond = 1'b1;
                    pcsource    = PCS_ALUOUT;
                    branch_type = branch_type_of(6'(op), rt[0]);
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = PCS_JUMP;
                end
                S_IMMEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    case (op)
                        OP_ANDI: aluop = ALU_AND;
                        OP_ORI:  aluop = ALU_OR;
                        default: aluop = ALU_ADD;
                    endcase
                end
                S_IMMWB: regwrite = 1'b1;
                S_JAL: begin
                    regwrite = 1'b1;
                    regdest  = 2'b10;
                    memtoreg = 2'b10;
                    pcwrite  = 1'b1;
                    pcsource = PCS_JUMP;
                end
                S_JR: begin
                    pcwrite  = 1'b1;
                    pcsource = PCS_RS;
                end
                default: pcwrite = 1'b0;
            endcase
        end else begin
            trap       = 1'b0;
            trap_cause = CAUSE_NONE;
            state_o    = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected per-cycle state
// and control word are queued with the stimulus and checked at each negedge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic [4:0] rt = 5'd0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic [1:0] regdest, memtoreg, alusrcb, pcsource, trap_cause;
    logic       regwrite, alusrca, trap;
    logic [2:0] aluop, branch_type;
    logic [4:0] link_reg;
    logic [3:0] state_o;
    logic [24:0] obs;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rt(rt), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdest(regdest), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .branch_type(branch_type), .link_reg(link_reg),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdest, memtoreg,
                  regwrite, alusrca, alusrcb, aluop, pcsource, branch_type, trap, trap_cause};

    // Reference control word per state, written from the controller's output table
    function automatic logic [24:0] model(input logic [3:0] st, input logic [5:0] o,
                                          input logic [4:0] r, input logic mr, input logic [1:0] c);
        logic pw, pwc, io, mrd, mwr, irw, rw, asa;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] aop, bt;
        pw = 1'b0; pwc = 1'b0; io = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; rw = 1'b0; asa = 1'b0;
        rd = 2'b00; m2r = 2'b00; asb = 2'b00; pcs = 2'b00; aop = 3'b000; bt = 3'b000;
        case (st)
            4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mrd = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 2'b01; end
            4'd5:  begin mwr = 1'b1; io = 1'b1; end
            4'd6:  begin asa = 1'b1; aop = 3'b010; end
            4'd7:  begin rw = 1'b1; rd = 2'b01; end
            4'd8: begin
                asa = 1'b1; aop = 3'b001; pwc = 1'b1; pcs = 2'b01;
                if (o == 6'b000100) bt = 3'b000;
                else if (o == 6'b000101) bt = 3'b001;
                else if (o == 6'b000111) bt = 3'b011;
                else if (o == 6'b000110) bt = 3'b100;
                else bt = r[0] ? 3'b010 : 3'b101;
            end
            4'd9:  begin pw = 1'b1; pcs = 2'b10; end
            4'd10: begin
                asa = 1'b1; asb = 2'b10;
                aop = (o == 6'b001100) ? 3'b011 : ((o == 6'b001101) ? 3'b100 : 3'b000);
            end
            4'd11: rw = 1'b1;
            4'd12: begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; pw = 1'b1; pcs = 2'b10; end
            4'd13: begin pw = 1'b1; pcs = 2'b11; end
            default: pw = 1'b0;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, pcs, bt, (c != 2'b00), c};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [1:0] c, input int n);
        exp_t e;
        e.st = st; e.mr = mr; e.cause = c;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic run();
        exp_t e;
        logic [24:0] want;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            @(negedge clk);
            want = model(e.st, op, rt, e.mr, e.cause);
            n_checks = n_checks + 1;
            assert (state_o === e.st) begin n_pass = n_pass + 1; end
            else $error("FAIL state t=%0t observed=%0d expected=%0d", $time, state_o, e.st);
            n_checks = n_checks + 1;
            assert (obs === want) begin n_pass = n_pass + 1; end
            else $error("FAIL ctrl st=%0d t=%0t observed=%h expected=%h", e.st, $time, obs, want);
            if (e.st == 4'd12) begin
                n_checks = n_checks + 1;
                assert (link_reg === 5'd31) begin n_pass = n_pass + 1; end
                else $error("FAIL link_reg observed=%0d expected=31", link_reg);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        n_checks = n_checks + 1;
        assert (obs === 25'd0 && state_o === 4'd0) begin n_pass = n_pass + 1; end
        else $error("FAIL %s observed=%h/%0d expected=0/0", tag, obs, state_o);
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
        op = o; funct = f; rt = r;
    endtask

    initial begin
        logic [5:0] bops [4];
        logic [5:0] iops [3];
        bops[0] = 6'b000100; bops[1] = 6'b000101; bops[2] = 6'b000110; bops[3] = 6'b000111;
        iops[0] = 6'b001000; iops[1] = 6'b001100; iops[2] = 6'b001101;
        #2;
        chk_zero("reset_outputs");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type add: 0,1,6,7 then back to FETCH
        instr(6'b000000, 6'b100000, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1);
        push(4'd6, 1'b1, 2'b00, 1); push(4'd7, 1'b1, 2'b00, 1);
        run();

        // lw with 3 FETCH waits and 2 MEMRD waits: 10 cycles
        instr(6'b100011, 6'd0, 5'd0);
        push(4'd0, 1'b0, 2'b00, 3); push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b0, 2'b00, 1);
        push(4'd2, 1'b1, 2'b00, 1); push(4'd3, 1'b0, 2'b00, 2); push(4'd3, 1'b1, 2'b00, 1);
        push(4'd4, 1'b1, 2'b00, 1);
        run();

        // sw with immediate ready
        instr(6'b101011, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1);
        push(4'd2, 1'b0, 2'b00, 1); push(4'd5, 1'b1, 2'b00, 1);
        run();

        // bgez then bltz
        for (int k = 1; k >= 0; k--) begin
            instr(6'b000001, 6'd0, 5'(k));
            push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd8, 1'b1, 2'b00, 1);
            run();
        end

        // beq / bne / blez / bgtz
        for (int k = 0; k < 4; k++) begin
            instr(bops[k], 6'd0, 5'd0);
            push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b0, 2'b00, 1); push(4'd8, 1'b0, 2'b00, 1);
            run();
        end

        // addi / andi / ori
        for (int k = 0; k < 3; k++) begin
            instr(iops[k], 6'd0, 5'd0);
            push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1);
            push(4'd10, 1'b1, 2'b00, 1); push(4'd11, 1'b1, 2'b00, 1);
            run();
        end

        // jal, j, jr
        instr(6'b000011, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd12, 1'b1, 2'b00, 1);
        run();
        instr(6'b000010, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd9, 1'b1, 2'b00, 1);
        run();
        instr(6'b000000, 6'b001000, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd13, 1'b1, 2'b00, 1);
        run();

        // Reset in the middle of MEMRD, then 11 FETCH waits must not trap
        instr(6'b100011, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1);
        push(4'd2, 1'b1, 2'b00, 1); push(4'd3, 1'b0, 2'b00, 1);
        run();
        rst_n = 1'b0;
        #1;
        chk_zero("reset_in_memrd");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        push(4'd0, 1'b0, 2'b00, 11); push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1);
        push(4'd2, 1'b1, 2'b00, 1); push(4'd3, 1'b1, 2'b00, 1); push(4'd4, 1'b1, 2'b00, 1);
        run();

        // MEMWR timeout after 12 not-ready cycles; trap sticks for 20 cycles
        instr(6'b101011, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd2, 1'b1, 2'b00, 1);
        push(4'd5, 1'b0, 2'b00, 12); push(4'd14, 1'b1, 2'b10, 20);
        run();

        // Illegal opcode after a fresh reset
        rst_n = 1'b0;
        #1;
        chk_zero("reset_from_trap");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        instr(6'b111111, 6'd0, 5'd0);
        push(4'd0, 1'b1, 2'b00, 1); push(4'd1, 1'b1, 2'b00, 1); push(4'd14, 1'b1, 2'b01, 3);
        run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
